cache_fill_ctrl: RTL and testbench

//  Lookup/miss/fill sequencer for one 4-set x 4-way cache tag array, upstream of the tag store.
//  - Latches a request and drives the tag store's index and tag.
//  - Qualifies its raw per-way hit vector with locally held valid bits.
//  - Picks a victim by first-invalid-way, else tree-PLRU.
//  - Runs the memory fill handshake, then issues the one-cycle tag write to the chosen way.

---
 rtl/cache_fill_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: lookup/miss/fill sequencer for a 4-set x 4-way cache tag array.
// Define CACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_fill_ctrl #(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_index,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [1:0]       ts_index,
    output logic [TAG_W-1:0] ts_tag,
    output logic [3:0]       ts_way,
    output logic             ts_w,
    input  logic [3:0]       ts_hit,
    output logic             mem_req,
    output logic [1:0]       mem_index,
    output logic [TAG_W-1:0] mem_tag,
    input  logic             mem_ack,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [3:0]       resp_way
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    typedef enum logic [2:0] {StIdle, StLookup, StMissReq, StFill, StResp} state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       victim_q;
    logic [3:0]       valid_q [4];
    logic [2:0]       plru_q [4];

    logic [3:0] qhit;
    logic [3:0] hit_way;
    logic [3:0] victim_way;

    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (v[0])      r = 4'b0001;
        else if (v[1]) r = 4'b0010;
        else if (v[2]) r = 4'b0100;
        else if (v[3]) r = 4'b1000;
        return r;
    endfunction

    // Tree bits: [0] selects pair, [1] picks within {0,1}, [2] picks within {2,3}.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [3:0] w);
        logic [2:0] r;
        r = b;
        if (w[0])      begin r[0] = 1'b1; r[1] = 1'b1; end
        else if (w[1]) begin r[0] = 1'b1; r[1] = 1'b0; end
        else if (w[2]) begin r[0] = 1'b0; r[2] = 1'b1; end
        else if (w[3]) begin r[0] = 1'b0; r[2] = 1'b0; end
        return r;
    endfunction

    function automatic logic [3:0] pick_victim(input logic [3:0] v, input logic [2:0] b);
        logic [3:0] r;
        if (v != 4'b1111) r = lowest_one(~v);
        else if (!b[0])   r = b[1] ? 4'b0010 : 4'b0001;
        else              r = b[2] ? 4'b1000 : 4'b0100;
        return r;
    endfunction

    assign qhit       = ts_hit & valid_q[idx_q];
    assign hit_way    = lowest_one(qhit);
    assign victim_way = pick_victim(valid_q[idx_q], plru_q[idx_q]);

    assign req_ready = (state_q == StIdle) && !flush;
    assign ts_index  = idx_q;
    assign ts_tag    = tag_q;
    assign mem_index = idx_q;
    assign mem_tag   = tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            tag_q      <= '0;
            victim_q   <= '0;
            ts_way     <= '0;
            ts_w       <= 1'b0;
            mem_req    <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            for (int s = 0; s < 4; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        for (int s = 0; s < 4; s++) begin
                            valid_q[s] <= '0;
                            plru_q[s]  <= '0;
                        end
                    end else if (req_valid) begin
                        idx_q   <= req_index;
                        tag_q   <= req_tag;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (qhit != 4'b0000) begin
                        plru_q[idx_q] <= plru_touch(plru_q[idx_q], hit_way);
                        resp_hit      <= 1'b1;
                        resp_way      <= hit_way;
                        resp_valid    <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        victim_q <= victim_way;
                        mem_req  <= 1'b1;
                        state_q  <= StMissReq;
                    end
                end
                StMissReq: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        ts_w    <= 1'b1;
                        ts_way  <= victim_q;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    ts_w           <= 1'b0;
                    ts_way         <= '0;
                    valid_q[idx_q] <= valid_q[idx_q] | victim_q;
                    plru_q[idx_q]  <= plru_touch(plru_q[idx_q], victim_q);
                    resp_hit       <= 1'b0;
                    resp_way       <= victim_q;
                    resp_valid     <= 1'b1;
                    state_q        <= StResp;
                end
                StResp: begin
                    resp_valid <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (resp_valid) begin
            if (resp_hit) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else if (miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: hit/miss/fill sequencing, PLRU victims, flush and reset.
module tb_cache_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_index;
    logic [7:0] req_tag;
    logic       flush;
    logic [1:0] ts_index;
    logic [7:0] ts_tag;
    logic [3:0] ts_way;
    logic       ts_w;
    logic [3:0] ts_hit;
    logic       mem_req;
    logic [1:0] mem_index;
    logic [7:0] mem_tag;
    logic       mem_ack;
    logic       resp_valid;
    logic       resp_hit;
    logic [3:0] resp_way;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cache_fill_ctrl #(.TAG_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .flush      (flush),
        .ts_index   (ts_index),
        .ts_tag     (ts_tag),
        .ts_way     (ts_way),
        .ts_w       (ts_w),
        .ts_hit     (ts_hit),
        .mem_req    (mem_req),
        .mem_index  (mem_index),
        .mem_tag    (mem_tag),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the last transaction.
    logic       r_hit;
    logic [3:0] r_way;
    logic [3:0] fill_way;
    int         wrote;
    int         lat;
    int         mem_cycles;
    int         mem_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in idle.
    // lat counts clock edges from the accept edge to the first cycle resp_valid is seen.
    task automatic transact(input logic [1:0] idx, input logic [7:0] tag,
                            input logic [3:0] hits, input int ack_wait);
        logic got;
        req_valid = 1'b1;
        req_index = idx;
        req_tag   = tag;
        ts_hit    = hits;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        lat        = 1;
        got        = 1'b0;
        wrote      = 0;
        fill_way   = 4'b0000;
        mem_cycles = 0;
        mem_bad    = 0;
        check("lookup_index", {30'd0, ts_index}, {30'd0, idx});
        check("lookup_tag", {24'd0, ts_tag}, {24'd0, tag});
        while (!got && lat < 40) begin
            if (mem_req) begin
                mem_cycles++;
                if (mem_tag !== tag || mem_index !== idx) mem_bad++;
                mem_ack = (mem_cycles > ack_wait);
            end else begin
                mem_ack = 1'b0;
            end
            if (ts_w) begin
                wrote++;
                fill_way = ts_way;
            end
            if (resp_valid) begin
                got   = 1'b1;
                r_hit = resp_hit;
                r_way = resp_way;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        mem_ack = 1'b0;
        check("resp_timeout", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        check("back_idle", {31'd0, req_ready & ~resp_valid}, 32'd1);
        ts_hit = 4'b0000;
    endtask

    task automatic expect_miss(input string tag, input logic [3:0] way, input int n_mem);
        check({tag, "_hit"}, {31'd0, r_hit}, 32'd0);
        check({tag, "_resp_way"}, {28'd0, r_way}, {28'd0, way});
        check({tag, "_fill_way"}, {28'd0, fill_way}, {28'd0, way});
        check({tag, "_ts_w_cycles"}, wrote, 32'd1);
        check({tag, "_mem_cycles"}, mem_cycles, n_mem);
        check({tag, "_mem_stable"}, mem_bad, 32'd0);
        check({tag, "_latency"}, lat, 32'(3 + n_mem));
    endtask

    task automatic expect_hit(input string tag, input logic [3:0] way);
        check({tag, "_hit"}, {31'd0, r_hit}, 32'd1);
        check({tag, "_resp_way"}, {28'd0, r_way}, {28'd0, way});
        check({tag, "_no_mem"}, mem_cycles, 32'd0);
        check({tag, "_no_write"}, wrote, 32'd0);
        check({tag, "_latency"}, lat, 32'd2);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_index = 2'd0;
        req_tag   = 8'h00;
        flush     = 1'b0;
        ts_hit    = 4'b0000;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_ts_w", {31'd0, ts_w}, 32'd0);
        check("rst_ts_way", {28'd0, ts_way}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_way", {28'd0, resp_way}, 32'd0);
        check("rst_ts_tag", {24'd0, ts_tag}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: cold miss, ack on the second mem_req cycle
        transact(2'd1, 8'hA5, 4'b0000, 1);
        expect_miss("t1", 4'b0001, 2);

        // 2: same line now hits
        transact(2'd1, 8'hA5, 4'b0001, 0);
        expect_hit("t2", 4'b0001);
`ifdef CACHE_PERF_CNT_EN
        check("perf_hit", {16'd0, hit_cnt}, 32'd1);
        check("perf_miss", {16'd0, miss_cnt}, 32'd1);
`endif

        // 3: fill set 2, touch way0, then PLRU victims 2,1,3,0
        transact(2'd2, 8'h10, 4'b0000, 0); expect_miss("t3_f0", 4'b0001, 1);
        transact(2'd2, 8'h11, 4'b0000, 0); expect_miss("t3_f1", 4'b0010, 1);
        transact(2'd2, 8'h12, 4'b0000, 0); expect_miss("t3_f2", 4'b0100, 1);
        transact(2'd2, 8'h13, 4'b0000, 0); expect_miss("t3_f3", 4'b1000, 1);
        transact(2'd2, 8'h10, 4'b0001, 0); expect_hit("t3_h0", 4'b0001);
        transact(2'd2, 8'h14, 4'b0000, 0); expect_miss("t3_v2", 4'b0100, 1);
        transact(2'd2, 8'h15, 4'b0000, 0); expect_miss("t3_v1", 4'b0010, 1);
        transact(2'd2, 8'h16, 4'b0000, 0); expect_miss("t3_v3", 4'b1000, 1);
        transact(2'd2, 8'h17, 4'b0000, 0); expect_miss("t3_v0", 4'b0001, 1);

        // 4: raw hits on invalid ways are masked; duplicates resolve low
        transact(2'd3, 8'h20, 4'b0000, 0); expect_miss("t4_f0", 4'b0001, 1);
        transact(2'd3, 8'h21, 4'b1110, 0); expect_miss("t4_mask", 4'b0010, 1);
        transact(2'd3, 8'h20, 4'b1111, 0); expect_hit("t4_dup", 4'b0001);
        transact(2'd3, 8'h21, 4'b1110, 0); expect_hit("t4_w1", 4'b0010);
        transact(2'd3, 8'h22, 4'b1100, 0); expect_miss("t4_v2", 4'b0100, 1);

        // 5: flush wins over a simultaneous request, then the old line misses
        flush     = 1'b1;
        req_valid = 1'b1;
        req_index = 2'd0;
        req_tag   = 8'h55;
        #1;
        check("flush_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("flush_not_accepted", {31'd0, req_ready}, 32'd1);
        transact(2'd1, 8'hA5, 4'b0001, 0);
        expect_miss("t5", 4'b0001, 1);

        // mem_ack while idle has no effect
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
        check("stray_ack_ready", {31'd0, req_ready}, 32'd1);
        mem_ack = 1'b0;

        // 6: reset while mem_req is high
        req_valid = 1'b1;
        req_index = 2'd1;
        req_tag   = 8'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_mem_req_up", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("t6_ts_w_drop", {31'd0, ts_w}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_ready", {31'd0, req_ready}, 32'd1);
        check("t6_mem_req_idle", {31'd0, mem_req}, 32'd0);
`ifdef CACHE_PERF_CNT_EN
        check("t6_perf_hit_clr", {16'd0, hit_cnt}, 32'd0);
        check("t6_perf_miss_clr", {16'd0, miss_cnt}, 32'd0);
`endif
        // valid bits were lost, so a hitting tag store still yields a miss
        transact(2'd1, 8'hA5, 4'b0001, 0);
        expect_miss("t6_lost", 4'b0001, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
